control_unit_fsm: RTL and testbench
===================================

Name: control_unit_fsm

Overview:
Multi-cycle LEGv8 control unit that sits directly upstream of the datapath. It latches the 32-bit instruction from the instruction ROM into an internal IR, sequences FETCH/EXEC/MEM/HALT, and drives the 30-bit control word and the 64-bit constant. The datapath consumes the control word and constant and returns the 5-bit status.

Parameters:
None; widths are fixed by the datapath.

Ports:
clock  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
instruction  in  32  ROM output for the current PC; sampled only in FETCH
status  in  5  {V,C,N,Z} registered flags in [4:1]; live ALU zero in [0]
control_word  out  30  {EN_PC,EN_Mem,EN_ALU,PCsel,Bsel,SL,WM,WR,PS[1:0],FS[4:0],SB[4:0],SA[4:0],DA[4:0]}, MSB first
constant  out  64  immediate or offset for the datapath
halted  out  1  high while in HALT

Behaviour:
- Reset:
  - On a rising edge with reset=1: state=FETCH, IR=0, halted=0.
  - While reset=1, control_word=0 and constant=0 combinationally. Reset mid-LDUR aborts it with no register write.
- FETCH:
  - control_word=0 (PS=00 holds PC; WR=WM=0).
  - Next edge: IR<=instruction, state<=EXEC.
- EXEC:
  - Decodes IR[31:21]. Next state is FETCH, except MEM for LDUR and HALT for an unmatched opcode.
  - Every instruction that leaves EXEC for FETCH asserts PS!=00, so PC changes exactly once per instruction.
- MEM (LDUR only):
  - Same address controls as EXEC, plus EN_Mem=1, WR=1, DA=Rt, PS=01.
  - Next state is FETCH.
- HALT:
  - control_word=0, halted=1. Held until reset.
- Resulting CPI: 2 cycles, except LDUR which takes 3.
- PS encoding: 00 hold; 01 PC+4; 10 PC+(constant<<2); 11 PC<=data bus.
- FS encoding:
  - FS[4:2] selects the operation: 000 AND, 001 ORR, 010 ADD, 011 EOR, 100 LSL, 101 LSR.
  - FS[1] inverts A; FS[0] inverts B and forms carry-in.
  - Resulting codes: ADD=01000, SUB=01001.
- Instruction fields: Rd/Rt=IR[4:0], Rn=IR[9:5], Rm=IR[20:16].
- Immediates:
  - I-type: IR[21:10], zero-extended.
  - D-type: IR[20:12], sign-extended.
  - B: IR[25:0], sign-extended.
  - CB: IR[23:5], sign-extended.
  - MOVZ: IR[20:5]<<(16*IR[22:21]).
  - Shift amount: IR[15:10].
- R-type (ADD, SUB, AND, ORR, EOR, ADDS, SUBS):
  - Opcodes: 10001011000, 11001011000, 10001010000, 10101010000, 11001010000, 10101011000, 11101011000.
  - SA=Rn, SB=Rm, DA=Rd, Bsel=0, EN_ALU=1, WR=1, PS=01.
  - SL=1 for ADDS/SUBS only.
- I-type (ADDI, SUBI, ANDI, ORRI, EORI):
  - Opcodes: 1001000100x, 1101000100x, 1001001000x, 1011001000x, 1101001000x.
  - Same as R-type but Bsel=1 and constant=imm12.
- LSL/LSR (11010011011/11010011010): Bsel=1, constant=shamt, EN_ALU=1, WR=1, PS=01.
- MOVZ (110100101xx): SA=31, Bsel=1, FS=00100, constant=shifted imm16, DA=Rd, EN_ALU=1, WR=1.
- LDUR (11111000010):
  - EXEC: SA=Rn, Bsel=1, FS=ADD, constant=offset; WR=0, PS=00.
  - Then MEM as above.
- STUR (11111000000): SA=Rn, SB=Rt, Bsel=1, FS=ADD, WM=1, PS=01.
- B (000101xxxxx): PS=10, constant=imm26.
- CBZ/CBNZ (10110100xxx/10110101xxx):
  - SA=Rt, SB=31, Bsel=0, FS=00100, constant=imm19.
  - PS=10 if status[0] equals CBZ, i.e. taken when zero for CBZ and when nonzero for CBNZ; otherwise PS=01.
- B.cond (01010100xxx):
  - Condition is IR[3:0], evaluated on status[4:1]: EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL (1110 and 1111 both mean always).
  - Taken gives PS=10, otherwise PS=01.
- Unused control fields are 0 in every state.
- Outputs are combinational from state, IR and status.

Test Plan:
- Reset for 2 cycles, then ADDI X1,X31,#5 (0x910017E1) → FETCH control_word=0. EXEC: SA=31, DA=1, Bsel=1, FS=01000, WR=1, EN_ALU=1, PS=01, constant=5; next state FETCH.
- LDUR X2,[X1,#8] (0xF8408022) → EXEC: WR=0, PS=00, constant=8. MEM: EN_Mem=1, WR=1, DA=2, PS=01. Total 3 cycles.
- CBZ X3,#4 (0xB4000083) → with status[0]=1: PS=10, constant=4. With status[0]=0: PS=01.
- B.GT (cond 1100) → with status[4:1]={V,C,N,Z}=0000: PS=10. With {0,0,1,0}: PS=01.
- Opcode 0x00000000 → HALT; halted=1 and control_word=0 for 10+ cycles; reset returns to FETCH with halted=0.
- reset=1 during the MEM cycle of an LDUR → control_word=0 that cycle (no WR); state is FETCH after the edge.

Source files
------------

// File: rtl/control_unit_fsm.sv
// Multi-cycle LEGv8 control unit: latches IR in FETCH, decodes in EXEC, finishes LDUR in MEM, parks in HALT.
// Latency: 2 cycles per instruction, 3 for LDUR; outputs are combinational from state, IR and status.
// Backpressure: none; the datapath consumes the control word every cycle and reset forces it to zero.
module control_unit_fsm (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [4:0]  status,
    output logic [29:0] control_word,
    output logic [63:0] constant,
    output logic        halted
);
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_MEM   = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BR   = 2'b10;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_EOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;
    localparam logic [4:0] XZR    = 5'd31;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] ir;

    logic [10:0] opc;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    assign opc = ir[31:21];
    assign rd  = ir[4:0];
    assign rn  = ir[9:5];
    assign rm  = ir[20:16];

    logic [63:0] imm_i;
    logic [63:0] imm_d;
    logic [63:0] imm_b;
    logic [63:0] imm_cb;
    logic [63:0] imm_mov;
    logic [63:0] imm_sh;
    assign imm_i   = {52'd0, ir[21:10]};
    assign imm_d   = {{55{ir[20]}}, ir[20:12]};
    assign imm_b   = {{38{ir[25]}}, ir[25:0]};
    assign imm_cb  = {{45{ir[23]}}, ir[23:5]};
    assign imm_mov = {48'd0, ir[20:5]} << {ir[22:21], 4'b0000};
    assign imm_sh  = {58'd0, ir[15:10]};

    // status[4:1] carries the registered {V,C,N,Z}; status[0] is the live ALU zero.
    logic flag_v;
    logic flag_c;
    logic flag_n;
    logic flag_z;
    logic cond_true;
    assign flag_v = status[4];
    assign flag_c = status[3];
    assign flag_n = status[2];
    assign flag_z = status[1];

    always_comb begin
        cond_true = 1'b1;
        case (ir[3:0])
            4'h0:    cond_true = flag_z;
            4'h1:    cond_true = !flag_z;
            4'h2:    cond_true = flag_c;
            4'h3:    cond_true = !flag_c;
            4'h4:    cond_true = flag_n;
            4'h5:    cond_true = !flag_n;
            4'h6:    cond_true = flag_v;
            4'h7:    cond_true = !flag_v;
            4'h8:    cond_true = flag_c && !flag_z;
            4'h9:    cond_true = !(flag_c && !flag_z);
            4'ha:    cond_true = (flag_n == flag_v);
            4'hb:    cond_true = (flag_n != flag_v);
            4'hc:    cond_true = !flag_z && (flag_n == flag_v);
            4'hd:    cond_true = !(!flag_z && (flag_n == flag_v));
            default: cond_true = 1'b1;
        endcase
    end

    logic        alu_r;
    logic        alu_i;
    logic        alu_s;
    logic        d_en_alu;
    logic        d_bsel;
    logic        d_sl;
    logic        d_wm;
    logic        d_wr;
    logic [1:0]  d_ps;
    logic [4:0]  d_fs;
    logic [4:0]  d_sb;
    logic [4:0]  d_sa;
    logic [4:0]  d_da;
    logic [63:0] d_const;
    logic        d_ldur;
    logic        d_bad;

    always_comb begin
        alu_r    = 1'b0;
        alu_i    = 1'b0;
        alu_s    = 1'b0;
        d_en_alu = 1'b0;
        d_bsel   = 1'b0;
        d_sl     = 1'b0;
        d_wm     = 1'b0;
        d_wr     = 1'b0;
        d_ps     = PS_HOLD;
        d_fs     = FS_AND;
        d_sb     = 5'd0;
        d_sa     = 5'd0;
        d_da     = 5'd0;
        d_const  = 64'd0;
        d_ldur   = 1'b0;
        d_bad    = 1'b0;
        casez (opc)
            11'b10001011000: begin alu_r = 1'b1; d_fs = FS_ADD; end
            11'b11001011000: begin alu_r = 1'b1; d_fs = FS_SUB; end
            11'b10001010000: begin alu_r = 1'b1; d_fs = FS_AND; end
            11'b10101010000: begin alu_r = 1'b1; d_fs = FS_ORR; end
            11'b11001010000: begin alu_r = 1'b1; d_fs = FS_EOR; end
            11'b10101011000: begin alu_r = 1'b1; d_fs = FS_ADD; d_sl = 1'b1; end
            11'b11101011000: begin alu_r = 1'b1; d_fs = FS_SUB; d_sl = 1'b1; end
            11'b1001000100?: begin alu_i = 1'b1; d_fs = FS_ADD; end
            11'b1101000100?: begin alu_i = 1'b1; d_fs = FS_SUB; end
            11'b1001001000?: begin alu_i = 1'b1; d_fs = FS_AND; end
            11'b1011001000?: begin alu_i = 1'b1; d_fs = FS_ORR; end
            11'b1101001000?: begin alu_i = 1'b1; d_fs = FS_EOR; end
            11'b11010011011: begin alu_s = 1'b1; d_fs = FS_LSL; end
            11'b11010011010: begin alu_s = 1'b1; d_fs = FS_LSR; end
            11'b110100101??: begin
                d_sa     = XZR;
                d_bsel   = 1'b1;
                d_fs     = FS_ORR;
                d_const  = imm_mov;
                d_da     = rd;
                d_en_alu = 1'b1;
                d_wr     = 1'b1;
                d_ps     = PS_INC;
            end
            11'b11111000010: begin
                // Address phase only; the register write happens in MEM.
                d_ldur  = 1'b1;
                d_sa    = rn;
                d_bsel  = 1'b1;
                d_fs    = FS_ADD;
                d_const = imm_d;
            end
            11'b11111000000: begin
                d_sa    = rn;
                d_sb    = rd;
                d_bsel  = 1'b1;
                d_fs    = FS_ADD;
                d_const = imm_d;
                d_wm    = 1'b1;
                d_ps    = PS_INC;
            end
            11'b000101?????: begin
                d_ps    = PS_BR;
                d_const = imm_b;
            end
            11'b1011010????: begin
                // ir[24] clear means CBZ: taken when the zero flag matches.
                d_sa    = rd;
                d_sb    = XZR;
                d_fs    = FS_ORR;
                d_const = imm_cb;
                d_ps    = (status[0] == !ir[24]) ? PS_BR : PS_INC;
            end
            11'b01010100???: begin
                d_const = imm_cb;
                d_ps    = cond_true ? PS_BR : PS_INC;
            end
            default: d_bad = 1'b1;
        endcase
        if (alu_r || alu_i || alu_s) begin
            d_sa     = rn;
            d_da     = rd;
            d_en_alu = 1'b1;
            d_wr     = 1'b1;
            d_ps     = PS_INC;
        end
        if (alu_r) d_sb = rm;
        if (alu_i) begin
            d_bsel  = 1'b1;
            d_const = imm_i;
        end
        if (alu_s) begin
            d_bsel  = 1'b1;
            d_const = imm_sh;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC:  state_nxt = d_bad ? S_HALT : (d_ldur ? S_MEM : S_FETCH);
            S_MEM:   state_nxt = S_FETCH;
            default: state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_FETCH;
            ir    <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH) ir <= instruction;
        end
    end

    always_comb begin
        control_word = 30'd0;
        constant     = 64'd0;
        if (!reset) begin
            case (state)
                S_EXEC: begin
                    control_word = {1'b0, 1'b0, d_en_alu, 1'b0, d_bsel, d_sl, d_wm, d_wr,
                                    d_ps, d_fs, d_sb, d_sa, d_da};
                    constant     = d_const;
                end
                S_MEM: begin
                    control_word = {1'b0, 1'b1, 1'b0, 1'b0, d_bsel, 1'b0, 1'b0, 1'b1,
                                    PS_INC, d_fs, d_sb, d_sa, rd};
                    constant     = d_const;
                end
                default: ;
            endcase
        end
    end

    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_control_unit_fsm.sv
// Randomized scoreboard bench for control_unit_fsm against an instruction-level reference model.
module tb_control_unit_fsm;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = 32'd0;
    logic [4:0]  status = 5'd0;
    logic [29:0] control_word;
    logic [63:0] constant;
    logic        halted;

    always #5 clock = ~clock;

    control_unit_fsm dut (
        .clock        (clock),
        .reset        (reset),
        .instruction  (instruction),
        .status       (status),
        .control_word (control_word),
        .constant     (constant),
        .halted       (halted)
    );

    typedef struct packed {
        logic        en_mem;
        logic        en_alu;
        logic        bsel;
        logic        sl;
        logic        wm;
        logic        wr;
        logic [1:0]  ps;
        logic [4:0]  fs;
        logic [4:0]  sb;
        logic [4:0]  sa;
        logic [4:0]  da;
        logic [63:0] k;
    } fld_t;

    typedef struct packed {
        logic [29:0] cw;
        logic [63:0] k;
        logic        h;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Instruction-level model: cycles already spent on the current instruction.
    logic [31:0] m_ir = 32'd0;
    int          m_cyc = 0;
    bit          m_halt = 1'b0;

    function automatic logic [29:0] pack_cw(input fld_t f);
        return {1'b0, f.en_mem, f.en_alu, 1'b0, f.bsel, f.sl, f.wm, f.wr, f.ps, f.fs, f.sb, f.sa, f.da};
    endfunction

    function automatic bit cond_holds(input logic [3:0] c, input logic [4:0] st);
        bit v, cf, n, z, t;
        v = st[4]; cf = st[3]; n = st[2]; z = st[1];
        case (c[3:1])
            3'd0: t = z;
            3'd1: t = cf;
            3'd2: t = n;
            3'd3: t = v;
            3'd4: t = cf && !z;
            3'd5: t = (n == v);
            3'd6: t = (n == v) && !z;
            default: t = 1'b1;
        endcase
        if (c[0] && c != 4'hf) t = !t;
        return t;
    endfunction

    function automatic fld_t ref_exec(input logic [31:0] ir, input logic [4:0] st,
                                      output int cpi, output bit bad);
        fld_t f;
        int   op;
        bit   rr, ii, sh;
        f = '0; cpi = 2; bad = 1'b0; rr = 0; ii = 0; sh = 0;
        op = int'(ir[31:21]);
        if      (op == 'b10001011000) begin rr = 1; f.fs = 5'b01000; end
        else if (op == 'b11001011000) begin rr = 1; f.fs = 5'b01001; end
        else if (op == 'b10001010000) begin rr = 1; f.fs = 5'b00000; end
        else if (op == 'b10101010000) begin rr = 1; f.fs = 5'b00100; end
        else if (op == 'b11001010000) begin rr = 1; f.fs = 5'b01100; end
        else if (op == 'b10101011000) begin rr = 1; f.fs = 5'b01000; f.sl = 1; end
        else if (op == 'b11101011000) begin rr = 1; f.fs = 5'b01001; f.sl = 1; end
        else if ((op >> 1) == 'b1001000100) begin ii = 1; f.fs = 5'b01000; end
        else if ((op >> 1) == 'b1101000100) begin ii = 1; f.fs = 5'b01001; end
        else if ((op >> 1) == 'b1001001000) begin ii = 1; f.fs = 5'b00000; end
        else if ((op >> 1) == 'b1011001000) begin ii = 1; f.fs = 5'b00100; end
        else if ((op >> 1) == 'b1101001000) begin ii = 1; f.fs = 5'b01100; end
        else if (op == 'b11010011011) begin sh = 1; f.fs = 5'b10000; end
        else if (op == 'b11010011010) begin sh = 1; f.fs = 5'b10100; end
        else if ((op >> 2) == 'b110100101) begin
            f.sa = 5'd31; f.bsel = 1; f.fs = 5'b00100; f.da = ir[4:0];
            f.en_alu = 1; f.wr = 1; f.ps = 2'b01;
            f.k = 64'(ir[20:5]) << (int'(ir[22:21]) * 16);
        end
        else if (op == 'b11111000010) begin
            cpi = 3; f.sa = ir[9:5]; f.bsel = 1; f.fs = 5'b01000;
            f.k = 64'($signed(ir[20:12]));
        end
        else if (op == 'b11111000000) begin
            f.sa = ir[9:5]; f.sb = ir[4:0]; f.bsel = 1; f.fs = 5'b01000; f.wm = 1; f.ps = 2'b01;
            f.k = 64'($signed(ir[20:12]));
        end
        else if ((op >> 5) == 'b000101) begin
            f.ps = 2'b10; f.k = 64'($signed(ir[25:0]));
        end
        else if ((op >> 3) == 'b10110100 || (op >> 3) == 'b10110101) begin
            bit is_cbz;
            is_cbz = ((op >> 3) == 'b10110100);
            f.sa = ir[4:0]; f.sb = 5'd31; f.fs = 5'b00100;
            f.k = 64'($signed(ir[23:5]));
            f.ps = (st[0] == is_cbz) ? 2'b10 : 2'b01;
        end
        else if ((op >> 3) == 'b01010100) begin
            f.k = 64'($signed(ir[23:5]));
            f.ps = cond_holds(ir[3:0], st) ? 2'b10 : 2'b01;
        end
        else bad = 1'b1;
        if (rr || ii || sh) begin
            f.sa = ir[9:5]; f.da = ir[4:0]; f.en_alu = 1; f.wr = 1; f.ps = 2'b01;
        end
        if (rr) f.sb = ir[20:16];
        if (ii) begin f.bsel = 1; f.k = 64'(ir[21:10]); end
        if (sh) begin f.bsel = 1; f.k = 64'(ir[15:10]); end
        return f;
    endfunction

    function automatic logic [31:0] gen_instr(input int kind);
        logic [31:0] r;
        r = $urandom;
        case (kind)
            0: case ($urandom_range(0, 6))
                   0: r[31:21] = 11'b10001011000;
                   1: r[31:21] = 11'b11001011000;
                   2: r[31:21] = 11'b10001010000;
                   3: r[31:21] = 11'b10101010000;
                   4: r[31:21] = 11'b11001010000;
                   5: r[31:21] = 11'b10101011000;
                   default: r[31:21] = 11'b11101011000;
               endcase
            1: case ($urandom_range(0, 4))
                   0: r[31:22] = 10'b1001000100;
                   1: r[31:22] = 10'b1101000100;
                   2: r[31:22] = 10'b1001001000;
                   3: r[31:22] = 10'b1011001000;
                   default: r[31:22] = 10'b1101001000;
               endcase
            2: r[31:21] = ($urandom_range(0, 1) != 0) ? 11'b11010011011 : 11'b11010011010;
            3: r[31:23] = 9'b110100101;
            4: r[31:21] = 11'b11111000010;
            5: r[31:21] = 11'b11111000000;
            6: r[31:26] = 6'b000101;
            7: r[31:24] = ($urandom_range(0, 1) != 0) ? 8'b10110100 : 8'b10110101;
            8: r[31:24] = 8'b01010100;
            default: r[31:21] = 11'd0;
        endcase
        return r;
    endfunction

    task automatic step(input bit rst, input logic [31:0] ins, input logic [4:0] st, input string tag);
        fld_t f;
        exp_t e;
        int   cpi;
        bit   bad;
        reset = rst; instruction = ins; status = st;
        e = '0;
        e.h = m_halt;
        if (!rst && !m_halt && m_cyc != 0) begin
            f = ref_exec(m_ir, st, cpi, bad);
            if (m_cyc == 2) begin
                f.en_mem = 1; f.wr = 1; f.da = m_ir[4:0]; f.ps = 2'b01;
            end
            e.cw = pack_cw(f);
            e.k  = f.k;
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        if (rst) begin
            m_cyc = 0; m_halt = 0; m_ir = 32'd0;
        end else if (!m_halt) begin
            if (m_cyc == 0) begin
                m_ir = ins; m_cyc = 1;
            end else begin
                f = ref_exec(m_ir, st, cpi, bad);
                if (bad) begin m_halt = 1; m_cyc = 0; end
                else if (m_cyc + 1 >= cpi) m_cyc = 0;
                else m_cyc = m_cyc + 1;
            end
        end
    endtask

    task automatic check(input string tag, input string what, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s.%s @%0t: got %h, expected %h", tag, what, $time, act, expv);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, "control_word", {34'd0, control_word}, {34'd0, e.cw});
            check(t, "constant", constant, e.k);
            check(t, "halted", {63'd0, halted}, {63'd0, e.h});
        end
    end

    localparam logic [31:0] I_ADDI = 32'h910017E1;
    localparam logic [31:0] I_LDUR = 32'hF8408022;
    localparam logic [31:0] I_CBZ  = 32'hB4000083;
    localparam logic [31:0] I_BGT  = 32'h540000EC;

    initial begin
        int hold_cnt;
        int kind;
        hold_cnt = 0;
        reset = 1'b1;
        @(posedge clock);
        #1;

        step(1, 32'd0, 5'd0, "reset_a");
        step(1, 32'd0, 5'd0, "reset_b");
        step(0, I_ADDI, 5'd0, "addi_fetch");
        step(0, I_ADDI, 5'd0, "addi_exec");
        step(0, I_LDUR, 5'd0, "ldur_fetch");
        step(0, I_LDUR, 5'd0, "ldur_exec");
        step(0, I_LDUR, 5'd0, "ldur_mem");
        step(0, I_CBZ, 5'd0, "cbz_fetch");
        step(0, I_CBZ, 5'b00001, "cbz_taken");
        step(0, I_CBZ, 5'd0, "cbz_fetch2");
        step(0, I_CBZ, 5'b00000, "cbz_not_taken");
        step(0, I_BGT, 5'd0, "bgt_fetch");
        step(0, I_BGT, 5'b00000, "bgt_taken");
        step(0, I_BGT, 5'd0, "bgt_fetch2");
        step(0, I_BGT, 5'b00100, "bgt_not_taken");
        step(0, I_LDUR, 5'd0, "ldur2_fetch");
        step(0, I_LDUR, 5'd0, "ldur2_exec");
        step(1, I_LDUR, 5'd0, "ldur2_mem_reset");
        step(0, I_ADDI, 5'd0, "post_reset_fetch");
        step(0, I_ADDI, 5'd0, "post_reset_exec");
        step(0, 32'd0, 5'd0, "zero_fetch");
        step(0, 32'd0, 5'd0, "zero_exec");
        for (int i = 0; i < 12; i++) step(0, $urandom, 5'($urandom_range(0, 31)), "halt_hold");
        step(1, 32'd0, 5'd0, "halt_reset");
        step(0, I_ADDI, 5'd0, "after_halt_fetch");
        step(0, I_ADDI, 5'd0, "after_halt_exec");

        for (int i = 0; i < 1500; i++) begin
            if (m_halt) begin
                hold_cnt++;
                if (hold_cnt >= 11) begin
                    step(1, $urandom, 5'($urandom_range(0, 31)), "rand_halt_reset");
                    hold_cnt = 0;
                end else begin
                    step(0, $urandom, 5'($urandom_range(0, 31)), "rand_halt_hold");
                end
            end else if (m_cyc == 2 && $urandom_range(0, 3) == 0) begin
                step(1, $urandom, 5'($urandom_range(0, 31)), "rand_mem_reset");
            end else if ($urandom_range(0, 60) == 0) begin
                step(1, $urandom, 5'($urandom_range(0, 31)), "rand_reset");
            end else begin
                kind = $urandom_range(0, 40);
                kind = (kind <= 36) ? (kind % 9) : 9;
                step(0, gen_instr(kind), 5'($urandom_range(0, 31)), "rand");
            end
        end

        repeat (2) @(posedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected responses left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
